hysteresis_counter_table: RTL and testbench

//   Table of DEPTH hysteresis saturating counters, e.g. a branch-predictor pattern table.

---
 rtl/hysteresis_counter_table_pkg.sv | 30 +++
 rtl/hysteresis_saturating_counter_next.sv | 31 +++
 rtl/hysteresis_counter_table.sv | 166 ++++++++++++++++
 tb/tb_hysteresis_counter_table.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hysteresis_counter_table_pkg.sv
// Shared types and derived constants for the hysteresis counter table and its
// next-value helper.
package hysteresis_counter_table_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  // Last value of the "not taken" half of the range.
  function automatic int half_low(input int range);
    return range / 2 - 1;
  endfunction

  // First value of the "taken" half of the range.
  function automatic int half_high(input int range);
    return range / 2;
  endfunction

  // Landing value when an increment crosses up from half_low.
  function automatic int jump_low(input int range, input int coercivity);
    return range / 2 + coercivity;
  endfunction

  // Landing value when a decrement crosses down from half_high.
  function automatic int jump_high(input int range, input int coercivity);
    return range / 2 - 1 - coercivity;
  endfunction

endpackage

// File: rtl/hysteresis_saturating_counter_next.sv
// Combinational next-value rule for one hysteresis saturating counter.
// Shared by the counter table and any stand-alone hysteresis counter.
module hysteresis_saturating_counter_next
  import hysteresis_counter_table_pkg::*;
#(
  parameter int RANGE      = 4,
  parameter int COERCIVITY = 1,
  parameter int WIDTH      = $clog2(RANGE)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             increment,
  input  logic             decrement,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(RANGE - 1);
  localparam logic [WIDTH-1:0] HALF_LOW  = WIDTH'(half_low(RANGE));
  localparam logic [WIDTH-1:0] HALF_HIGH = WIDTH'(half_high(RANGE));
  localparam logic [WIDTH-1:0] JUMP_LOW  = WIDTH'(jump_low(RANGE, COERCIVITY));
  localparam logic [WIDTH-1:0] JUMP_HIGH = WIDTH'(jump_high(RANGE, COERCIVITY));

  always_comb begin
    next_count = count;
    if (increment && !decrement && count != MAX_COUNT) begin
      next_count = (count == HALF_LOW) ? JUMP_LOW : count + WIDTH'(1);
    end else if (decrement && !increment && count != '0) begin
      next_count = (count == HALF_HIGH) ? JUMP_HIGH : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/hysteresis_counter_table.sv
// Table of hysteresis saturating counters with lookup, valid/ready update and
// an init/flush sequencer. Optional HYSTERESIS_COUNTER_TABLE_BYPASS_EN forwards
// the pending write to the lookup port.
module hysteresis_counter_table
  import hysteresis_counter_table_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 1,
  parameter int COERCIVITY  = 1,
  parameter int WIDTH       = $clog2(RANGE),
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  output logic                   busy,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  output logic [WIDTH-1:0]       lookup_count,
  output logic                   lookup_taken,
  input  logic                   update_valid,
  output logic                   update_ready,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_increment,
  input  logic                   update_decrement
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);
  localparam logic [WIDTH-1:0]       INIT_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]       TAKEN_MIN  = WIDTH'(half_high(RANGE));

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [INDEX_WIDTH-1:0] pend_index_q, pend_index_d;
  logic [WIDTH-1:0]       pend_value_q, pend_value_d;

  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   accept;
  logic [WIDTH-1:0]       old_count;
  logic [WIDTH-1:0]       new_count;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [WIDTH-1:0]       wr_data;

  always_comb begin
    update_ready = (state_q == ST_READY) && !flush;
    busy         = busy_q;
    accept       = update_valid && update_ready;
  end

  // The pending slot holds the freshest value for its index, so same-index
  // back-to-back updates chain through it instead of the stale array entry.
  always_comb begin
    if (pend_valid_q && pend_index_q == update_index) begin
      old_count = pend_value_q;
    end else begin
      old_count = mem[update_index];
    end
  end

  hysteresis_saturating_counter_next #(
    .RANGE      (RANGE),
    .COERCIVITY (COERCIVITY),
    .WIDTH      (WIDTH)
  ) u_next (
    .count      (old_count),
    .increment  (update_increment),
    .decrement  (update_decrement),
    .next_count (new_count)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    init_ptr_d   = init_ptr_q;
    pend_valid_d = 1'b0;
    pend_index_d = pend_index_q;
    pend_value_d = pend_value_q;
    case (state_q)
      ST_INIT: begin
        if (init_ptr_q == LAST_INDEX) begin
          state_d    = ST_READY;
          busy_d     = 1'b0;
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + INDEX_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (flush) begin
          state_d    = ST_INIT;
          busy_d     = 1'b1;
          init_ptr_d = '0;
        end else if (accept) begin
          pend_valid_d = 1'b1;
          pend_index_d = update_index;
          pend_value_d = new_count;
        end
      end
      default: begin
        state_d    = ST_INIT;
        busy_d     = 1'b1;
        init_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_INIT;
      busy_q       <= 1'b1;
      init_ptr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_index_q <= '0;
      pend_value_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      init_ptr_q   <= init_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_index_q <= pend_index_d;
      pend_value_q <= pend_value_d;
    end
  end

  // Single write port: the init walk owns it while busy, the pending slot otherwise.
  always_comb begin
    if (state_q == ST_INIT) begin
      wr_en    = 1'b1;
      wr_index = init_ptr_q;
      wr_data  = INIT_COUNT;
    end else begin
      wr_en    = pend_valid_q;
      wr_index = pend_index_q;
      wr_data  = pend_value_q;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
  always_comb begin
    if (pend_valid_q && pend_index_q == lookup_index) begin
      lookup_count = pend_value_q;
    end else begin
      lookup_count = mem[lookup_index];
    end
  end
`else
  always_comb begin
    lookup_count = mem[lookup_index];
  end
`endif

  always_comb begin
    lookup_taken = lookup_count >= TAKEN_MIN;
  end

endmodule

// File: tb/tb_hysteresis_counter_table.sv
// Randomized self-checking bench for hysteresis_counter_table against an
// array-level reference model with per-build lookup visibility.
module tb_hysteresis_counter_table;

  localparam int DEPTH       = 16;
  localparam int RANGE       = 4;
  localparam int RESET_VALUE = 1;
  localparam int COERCIVITY  = 1;

  logic       clock = 1'b0;
  logic       resetn;
  logic       flush;
  logic       busy;
  logic [3:0] lookup_index;
  logic [1:0] lookup_count;
  logic       lookup_taken;
  logic       update_valid;
  logic       update_ready;
  logic [3:0] update_index;
  logic       update_increment;
  logic       update_decrement;

  int n_checks = 0;
  int n_errors = 0;

  // m_cur: value after every accepted update so far.
  // m_prev: value as it stood at the start of the previous cycle.
  int m_cur  [DEPTH];
  int m_prev [DEPTH];
  int init_left;

  hysteresis_counter_table #(
    .DEPTH       (DEPTH),
    .RANGE       (RANGE),
    .RESET_VALUE (RESET_VALUE),
    .COERCIVITY  (COERCIVITY)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .flush            (flush),
    .busy             (busy),
    .lookup_index     (lookup_index),
    .lookup_count     (lookup_count),
    .lookup_taken     (lookup_taken),
    .update_valid     (update_valid),
    .update_ready     (update_ready),
    .update_index     (update_index),
    .update_increment (update_increment),
    .update_decrement (update_decrement)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_next(input int c, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (c == RANGE - 1) return c;
      if (c == RANGE / 2 - 1) return RANGE / 2 + COERCIVITY;
      return c + 1;
    end
    if (dec && !inc) begin
      if (c == 0) return c;
      if (c == RANGE / 2) return RANGE / 2 - 1 - COERCIVITY;
      return c - 1;
    end
    return c;
  endfunction

  task automatic model_reset_all();
    for (int i = 0; i < DEPTH; i++) begin
      m_cur[i]  = RESET_VALUE;
      m_prev[i] = RESET_VALUE;
    end
  endtask

  // One clock cycle: drive at the falling edge, check shortly after, then
  // advance the model to what the following rising edge commits.
  task automatic cycle(input bit v, input int idx, input bit inc, input bit dec,
                       input bit fl, input int lidx);
    bit exp_busy;
    int exp_l;
    @(negedge clock);
    update_valid     = v;
    update_index     = 4'(idx);
    update_increment = inc;
    update_decrement = dec;
    flush            = fl;
    lookup_index     = 4'(lidx);
    #1;
    exp_busy = (init_left > 0);
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("update_ready", 32'(update_ready), 32'(!exp_busy && !fl));
    if (!exp_busy) begin
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
      exp_l = m_cur[lidx];
`else
      exp_l = m_prev[lidx];
`endif
      check_eq("lookup_count", 32'(lookup_count), 32'(exp_l));
      check_eq("lookup_taken", 32'(lookup_taken), 32'(exp_l >= RANGE / 2));
    end
    m_prev = m_cur;
    if (exp_busy) begin
      init_left--;
    end else if (fl) begin
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_cur[i] = RESET_VALUE;
    end else if (v) begin
      m_cur[idx] = model_next(m_cur[idx], inc, dec);
    end
  endtask

  task automatic idle(input int lidx, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, lidx);
  endtask

  // Asynchronous reset pulse placed between edges; restarts the init walk.
  task automatic pulse_reset();
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check_eq("reset_busy", 32'(busy), 32'd1);
    check_eq("reset_ready", 32'(update_ready), 32'd0);
    resetn = 1'b1;
    init_left = DEPTH;
    model_reset_all();
  endtask

  initial begin
    int cnt;
    int bad_ready;
    resetn           = 1'b0;
    flush            = 1'b0;
    lookup_index     = '0;
    update_valid     = 1'b0;
    update_index     = '0;
    update_increment = 1'b0;
    update_decrement = 1'b0;
    init_left        = 0;
    model_reset_all();

    repeat (3) @(negedge clock);
    #1;
    check_eq("por_busy", 32'(busy), 32'd1);
    check_eq("por_ready", 32'(update_ready), 32'd0);

    @(negedge clock);
    resetn = 1'b1;
    #1;
    cnt = 0;
    bad_ready = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (update_ready !== 1'b0) bad_ready++;
      cnt++;
      @(negedge clock);
      #1;
    end
    check_eq("init_cycles", 32'(cnt), 32'd16);
    check_eq("init_ready_low", 32'(bad_ready), 32'd0);

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, i);

    // Hysteresis walk on entry 5.
    cycle(1'b1, 5, 1'b1, 1'b0, 1'b0, 5); idle(5, 2);
    check_eq("idx5_inc_jump", 32'(lookup_count), 32'd3);
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0, 5); idle(5, 2);
    check_eq("idx5_dec", 32'(lookup_count), 32'd2);
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0, 5); idle(5, 2);
    check_eq("idx5_dec_jump", 32'(lookup_count), 32'd0);
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0, 5); idle(5, 2);
    check_eq("idx5_dec_sat", 32'(lookup_count), 32'd0);

    // Back-to-back increments on entry 7 chain through the pending slot.
    repeat (3) cycle(1'b1, 7, 1'b1, 1'b0, 1'b0, 7);
    idle(7, 2);
    check_eq("idx7_chain", 32'(lookup_count), 32'd3);
    cycle(1'b1, 7, 1'b1, 1'b1, 1'b0, 7); idle(7, 2);
    check_eq("idx7_both", 32'(lookup_count), 32'd3);

    // Update-to-lookup latency on entry 2.
    cycle(1'b1, 2, 1'b1, 1'b0, 1'b0, 2);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 2);
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
    check_eq("idx2_n1_bypass", 32'(lookup_count), 32'd3);
`else
    check_eq("idx2_n1_array", 32'(lookup_count), 32'd1);
`endif
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 2);
    check_eq("idx2_n2", 32'(lookup_count), 32'd3);

    // Flush wins over a simultaneous update.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, i, 1'b1, 1'b0, 1'b0, i);
      cycle(1'b1, i, 1'b1, 1'b0, 1'b0, i);
    end
    idle(0, 2);
    cycle(1'b1, 4, 1'b0, 1'b1, 1'b1, 4);
    repeat (DEPTH) cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, i);
    check_eq("flush_last_entry", 32'(lookup_count), 32'd1);

    // Reset during init at pointer 9.
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    idle(0, 9);
    pulse_reset();
    idle(0, DEPTH);
    idle(0, 1);

    // Reset with a write still pending.
    cycle(1'b1, 3, 1'b0, 1'b1, 1'b0, 3);
    pulse_reset();
    idle(3, DEPTH + 1);
    check_eq("pend_dropped", 32'(lookup_count), 32'd1);

    // Randomized traffic, occasional flushes, index bias for chaining.
    for (int n = 0; n < 600; n++) begin
      int idx;
      idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, DEPTH - 1));
      cycle($urandom_range(0, 3) != 0, idx, 1'($urandom), 1'($urandom),
            $urandom_range(0, 79) == 0, int'($urandom_range(0, DEPTH - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
